// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Arbitrates between an instruction-fetch requester (icache) and a load/store
//   requester (dcache) for a single memory port, routes the memory's
//   accept/response back to the winner, and routes returning load data to the
//   requester that owns the returning tag.
//
// Ports
//   clock, reset                 : clock (posedge), asynchronous active-low reset
//   icache2mem_command/addr      : instruction-fetch request
//   dcache2mem_command/addr/data : load/store request
//   proc2mem_command/addr/data   : request driven to memory (winner)
//   mem2proc_response/tag/data   : memory accept tag (0 = rejected) and data return
//   mem2icache_response/tag/data : routed response / return for icache
//   mem2dcache_response/tag/data : routed response / return for dcache
//   tag_error                    : sticky, data returned on a tag with no pending load
module mem_bus_arbiter #(
  parameter int unsigned NUM_MEM_TAGS = 15,
  parameter logic [1:0]  BUS_NONE     = 2'd0,
  parameter logic [1:0]  BUS_LOAD     = 2'd1,
  parameter logic [1:0]  BUS_STORE    = 2'd2
) (
  input  logic        clock,
  input  logic        reset,

  input  logic [1:0]  icache2mem_command,
  input  logic [63:0] icache2mem_addr,

  input  logic [1:0]  dcache2mem_command,
  input  logic [63:0] dcache2mem_addr,
  input  logic [63:0] dcache2mem_data,

  output logic [1:0]  proc2mem_command,
  output logic [63:0] proc2mem_addr,
  output logic [63:0] proc2mem_data,

  input  logic [3:0]  mem2proc_response,
  input  logic [3:0]  mem2proc_tag,
  input  logic [63:0] mem2proc_data,

  output logic [3:0]  mem2icache_response,
  output logic [3:0]  mem2icache_tag,
  output logic [63:0] mem2icache_data,

  output logic [3:0]  mem2dcache_response,
  output logic [3:0]  mem2dcache_tag,
  output logic [63:0] mem2dcache_data,

  output logic        tag_error
);

  localparam logic [4:0] MaxTag = 5'(NUM_MEM_TAGS);

  // Arbitration state: 0 = dcache has priority, 1 = icache has priority.
  logic                  r_prio;
  // Per-tag bookkeeping; entry 0 is never allocated (tag 0 means "none").
  logic [NUM_MEM_TAGS:0] r_owner;    // 0 = dcache, 1 = icache
  logic [NUM_MEM_TAGS:0] r_pending;
  logic                  r_tag_error;

  logic       w_d_act;
  logic       w_i_act;
  logic       w_has_win;
  logic       w_win_icache;
  logic [1:0] w_win_cmd;
  logic       w_accept;
  logic       w_alloc;
  logic       w_ret_valid;
  logic       w_ret_hit;
  logic       w_ret_owner;

  // Command 2'd3 is not a request, so only LOAD/STORE count as active.
  assign w_d_act = (dcache2mem_command == BUS_LOAD) || (dcache2mem_command == BUS_STORE);
  assign w_i_act = (icache2mem_command == BUS_LOAD) || (icache2mem_command == BUS_STORE);

  assign w_has_win    = w_d_act || w_i_act;
  assign w_win_icache = w_i_act && (!w_d_act || r_prio);
  assign w_win_cmd    = w_win_icache ? icache2mem_command : dcache2mem_command;

  assign w_accept = w_has_win && (mem2proc_response != 4'd0);
  // Responses beyond the tag space cannot be tracked, so they allocate nothing.
  assign w_alloc  = w_accept && (w_win_cmd == BUS_LOAD) && ({1'b0, mem2proc_response} <= MaxTag);

  assign w_ret_valid = (mem2proc_tag != 4'd0) && ({1'b0, mem2proc_tag} <= MaxTag);
  assign w_ret_hit   = w_ret_valid && r_pending[mem2proc_tag];
  assign w_ret_owner = r_owner[mem2proc_tag];

  // Request path to memory; forced idle while reset is held.
  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = 64'd0;
    proc2mem_data    = 64'd0;
    if (reset && w_has_win) begin
      if (w_win_icache) begin
        proc2mem_command = icache2mem_command;
        proc2mem_addr    = icache2mem_addr;
      end else begin
        proc2mem_command = dcache2mem_command;
        proc2mem_addr    = dcache2mem_addr;
        proc2mem_data    = dcache2mem_data;
      end
    end
  end

  // Accept/response goes only to the current winner.
  always_comb begin
    mem2icache_response = 4'd0;
    mem2dcache_response = 4'd0;
    if (reset && w_has_win) begin
      if (w_win_icache) mem2icache_response = mem2proc_response;
      else              mem2dcache_response = mem2proc_response;
    end
  end

  // Returning data follows the tag's registered owner (old owner on a same-cycle realloc).
  always_comb begin
    mem2icache_tag  = 4'd0;
    mem2icache_data = 64'd0;
    mem2dcache_tag  = 4'd0;
    mem2dcache_data = 64'd0;
    if (reset && w_ret_hit) begin
      if (w_ret_owner) begin
        mem2icache_tag  = mem2proc_tag;
        mem2icache_data = mem2proc_data;
      end else begin
        mem2dcache_tag  = mem2proc_tag;
        mem2dcache_data = mem2proc_data;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_prio      <= 1'b0;
      r_owner     <= '0;
      r_pending   <= '0;
      r_tag_error <= 1'b0;
    end else begin
      // Round robin: after an accepted grant the other requester gets priority.
      if (w_accept) r_prio <= !w_win_icache;
      if (w_ret_hit) r_pending[mem2proc_tag] <= 1'b0;
      if ((mem2proc_tag != 4'd0) && !w_ret_hit) r_tag_error <= 1'b1;
      // Placed after the clear so a same-tag allocation overrides it.
      if (w_alloc) begin
        r_owner[mem2proc_response]   <= w_win_icache;
        r_pending[mem2proc_response] <= 1'b1;
      end
    end
  end

  assign tag_error = r_tag_error;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench for mem_bus_arbiter: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_mem_bus_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  icache2mem_command = 2'd0;
  logic [63:0] icache2mem_addr = 64'd0;
  logic [1:0]  dcache2mem_command = 2'd0;
  logic [63:0] dcache2mem_addr = 64'd0;
  logic [63:0] dcache2mem_data = 64'd0;
  logic [1:0]  proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response = 4'd0;
  logic [3:0]  mem2proc_tag = 4'd0;
  logic [63:0] mem2proc_data = 64'd0;
  logic [3:0]  mem2icache_response;
  logic [3:0]  mem2icache_tag;
  logic [63:0] mem2icache_data;
  logic [3:0]  mem2dcache_response;
  logic [3:0]  mem2dcache_tag;
  logic [63:0] mem2dcache_data;
  logic        tag_error;

  mem_bus_arbiter dut (
    .clock               (clock),
    .reset               (reset),
    .icache2mem_command  (icache2mem_command),
    .icache2mem_addr     (icache2mem_addr),
    .dcache2mem_command  (dcache2mem_command),
    .dcache2mem_addr     (dcache2mem_addr),
    .dcache2mem_data     (dcache2mem_data),
    .proc2mem_command    (proc2mem_command),
    .proc2mem_addr       (proc2mem_addr),
    .proc2mem_data       (proc2mem_data),
    .mem2proc_response   (mem2proc_response),
    .mem2proc_tag        (mem2proc_tag),
    .mem2proc_data       (mem2proc_data),
    .mem2icache_response (mem2icache_response),
    .mem2icache_tag      (mem2icache_tag),
    .mem2icache_data     (mem2icache_data),
    .mem2dcache_response (mem2dcache_response),
    .mem2dcache_tag      (mem2dcache_tag),
    .mem2dcache_data     (mem2dcache_data),
    .tag_error           (tag_error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Reference model: who gets priority next, and a table of outstanding loads.
  bit m_icache_next;        // 1 when icache wins a tie
  int m_owner [16];         // 0 = dcache, 1 = icache
  bit m_pend  [16];
  bit m_err;

  task automatic chk(input string nm, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", nm, obs, exp);
    end
  endtask

  function automatic bit is_req(input logic [1:0] c);
    return (c == 2'd1) || (c == 2'd2);
  endfunction

  task automatic model_reset();
    m_icache_next = 1'b0;
    m_err = 1'b0;
    for (int k = 0; k < 16; k++) begin
      m_owner[k] = 0;
      m_pend[k]  = 1'b0;
    end
  endtask

  // One bus cycle: drive at negedge, check the combinational outputs,
  // then advance the model to the state after the coming posedge.
  task automatic cycle(input logic [1:0] dc, input logic [63:0] da, input logic [63:0] dd,
                       input logic [1:0] ic, input logic [63:0] ia,
                       input logic [3:0] rsp, input logic [3:0] tg, input logic [63:0] td);
    int who;   // -1 none, 0 dcache, 1 icache
    bit hit;
    logic [1:0]  e_cmd;
    logic [63:0] e_addr, e_data;
    @(negedge clock);
    dcache2mem_command = dc; dcache2mem_addr = da; dcache2mem_data = dd;
    icache2mem_command = ic; icache2mem_addr = ia;
    mem2proc_response = rsp; mem2proc_tag = tg; mem2proc_data = td;
    #1;
    if (is_req(dc) && is_req(ic)) who = m_icache_next ? 1 : 0;
    else if (is_req(dc))          who = 0;
    else if (is_req(ic))          who = 1;
    else                          who = -1;
    e_cmd  = (who == 0) ? dc : (who == 1) ? ic : 2'd0;
    e_addr = (who == 0) ? da : (who == 1) ? ia : 64'd0;
    e_data = (who == 0) ? dd : 64'd0;
    hit = (tg != 4'd0) && m_pend[int'(tg)];
    chk("proc2mem_command", 64'(proc2mem_command), 64'(e_cmd));
    chk("proc2mem_addr", proc2mem_addr, e_addr);
    chk("proc2mem_data", proc2mem_data, e_data);
    chk("dcache_response", 64'(mem2dcache_response), (who == 0) ? 64'(rsp) : 64'd0);
    chk("icache_response", 64'(mem2icache_response), (who == 1) ? 64'(rsp) : 64'd0);
    chk("dcache_tag", 64'(mem2dcache_tag), (hit && m_owner[int'(tg)] == 0) ? 64'(tg) : 64'd0);
    chk("icache_tag", 64'(mem2icache_tag), (hit && m_owner[int'(tg)] == 1) ? 64'(tg) : 64'd0);
    chk("dcache_data", mem2dcache_data, (hit && m_owner[int'(tg)] == 0) ? td : 64'd0);
    chk("icache_data", mem2icache_data, (hit && m_owner[int'(tg)] == 1) ? td : 64'd0);
    chk("tag_error", 64'(tag_error), 64'(m_err));
    // Next state: return retires first, then a new load claims its tag.
    if (tg != 4'd0) begin
      if (hit) m_pend[int'(tg)] = 1'b0;
      else     m_err = 1'b1;
    end
    if (who >= 0 && rsp != 4'd0) begin
      m_icache_next = (who == 0);
      if (e_cmd == 2'd1) begin
        m_owner[int'(rsp)] = who;
        m_pend[int'(rsp)]  = 1'b1;
      end
    end
  endtask

  task automatic idle();
    cycle(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 4'd0, 4'd0, 64'd0);
  endtask

  initial begin
    model_reset();
    // Held in reset with live requests: memory side must stay quiet.
    dcache2mem_command = 2'd1; icache2mem_command = 2'd1;
    mem2proc_response = 4'd3; mem2proc_tag = 4'd3;
    #2;
    chk("rst_command", 64'(proc2mem_command), 64'd0);
    chk("rst_dresp", 64'(mem2dcache_response), 64'd0);
    chk("rst_iresp", 64'(mem2icache_response), 64'd0);
    chk("rst_dtag", 64'(mem2dcache_tag), 64'd0);
    chk("rst_itag", 64'(mem2icache_tag), 64'd0);
    chk("rst_tag_error", 64'(tag_error), 64'd0);
    @(negedge clock);
    dcache2mem_command = 2'd0; icache2mem_command = 2'd0;
    mem2proc_response = 4'd0; mem2proc_tag = 4'd0;
    reset = 1'b1;

    // Both load from reset: dcache first, then icache.
    cycle(2'd1, 64'h100, 64'd0, 2'd1, 64'h200, 4'd3, 4'd0, 64'd0);
    chk("both_first_addr", proc2mem_addr, 64'h100);
    chk("both_first_dresp", 64'(mem2dcache_response), 64'd3);
    cycle(2'd1, 64'h100, 64'd0, 2'd1, 64'h200, 4'd6, 4'd0, 64'd0);
    chk("both_second_addr", proc2mem_addr, 64'h200);

    // Rejections hold priority; dcache keeps winning until accepted.
    for (int k = 0; k < 3; k++) begin
      cycle(2'd1, 64'h100, 64'd0, 2'd1, 64'h200, 4'd0, 4'd0, 64'd0);
      chk("reject_hold_addr", proc2mem_addr, 64'h100);
    end
    cycle(2'd1, 64'h100, 64'd0, 2'd1, 64'h200, 4'd5, 4'd0, 64'd0);
    chk("accept_dresp", 64'(mem2dcache_response), 64'd5);
    cycle(2'd1, 64'h100, 64'd0, 2'd1, 64'h200, 4'd0, 4'd0, 64'd0);
    chk("prio_flipped_addr", proc2mem_addr, 64'h200);

    // icache load on tag 2, then data returns on tag 2.
    cycle(2'd0, 64'd0, 64'd0, 2'd1, 64'h300, 4'd2, 4'd0, 64'd0);
    cycle(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 4'd0, 4'd2, 64'hDEADBEEF);
    chk("ret2_itag", 64'(mem2icache_tag), 64'd2);
    chk("ret2_idata", mem2icache_data, 64'hDEADBEEF);
    chk("ret2_dtag", 64'(mem2dcache_tag), 64'd0);

    // Store on tag 4 allocates nothing; its return is an error.
    cycle(2'd2, 64'h400, 64'h55, 2'd0, 64'd0, 4'd4, 4'd0, 64'd0);
    cycle(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 4'd0, 4'd4, 64'h1234);
    chk("store_ret_dtag", 64'(mem2dcache_tag), 64'd0);
    chk("store_ret_itag", 64'(mem2icache_tag), 64'd0);
    @(posedge clock); #1;
    chk("store_ret_error", 64'(tag_error), 64'd1);
    // Tag 2 was retired, so a second return routes nowhere.
    cycle(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 4'd0, 4'd2, 64'h77);
    chk("ret2_again_itag", 64'(mem2icache_tag), 64'd0);

    // Same-cycle return and reallocation of tag 1.
    cycle(2'd0, 64'd0, 64'd0, 2'd1, 64'h500, 4'd1, 4'd0, 64'd0);
    cycle(2'd1, 64'h600, 64'd0, 2'd0, 64'd0, 4'd1, 4'd1, 64'hCAFE);
    chk("realloc_itag", 64'(mem2icache_tag), 64'd1);
    chk("realloc_idata", mem2icache_data, 64'hCAFE);
    cycle(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 4'd0, 4'd1, 64'hF00D);
    chk("realloc_dtag", 64'(mem2dcache_tag), 64'd1);
    chk("realloc_ddata", mem2dcache_data, 64'hF00D);

    // Two loads pending, then a reset pulse between negedge and posedge.
    cycle(2'd1, 64'h700, 64'd0, 2'd0, 64'd0, 4'd7, 4'd0, 64'd0);
    cycle(2'd0, 64'd0, 64'd0, 2'd1, 64'h800, 4'd8, 4'd0, 64'd0);
    @(negedge clock);
    dcache2mem_command = 2'd1; icache2mem_command = 2'd1;
    mem2proc_response = 4'd9; mem2proc_tag = 4'd0;
    #2 reset = 1'b0;
    #1;
    chk("pulse_command", 64'(proc2mem_command), 64'd0);
    chk("pulse_dresp", 64'(mem2dcache_response), 64'd0);
    chk("pulse_tag_error", 64'(tag_error), 64'd0);
    dcache2mem_command = 2'd0; icache2mem_command = 2'd0; mem2proc_response = 4'd0;
    #1 reset = 1'b1;
    model_reset();
    cycle(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 4'd0, 4'd7, 64'h11);
    chk("post_rst7_dtag", 64'(mem2dcache_tag), 64'd0);
    cycle(2'd0, 64'd0, 64'd0, 2'd0, 64'd0, 4'd0, 4'd8, 64'h22);
    chk("post_rst8_itag", 64'(mem2icache_tag), 64'd0);
    chk("post_rst_error", 64'(tag_error), 64'd1);

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      logic [3:0] rsp, tg;
      rsp = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      tg  = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      cycle(2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
            2'($urandom_range(0, 3)), {$urandom, $urandom}, rsp, tg, {$urandom, $urandom});
    end
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter NUM_MEM_TAGS, default 15, number of memory tags (tag 0 = none).
REQ-002 SHALL have parameter BUS_NONE/BUS_LOAD/BUS_STORE, defaults 2'd0/2'd1/2'd2, bus command encodings.
REQ-003 SHALL have port clock  input  1  single clock, all state updates on posedge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports icache2mem_command  input  2, and icache2mem_addr  input  64: instruction-fetch requester.
REQ-006 SHALL have ports dcache2mem_command  input  2, dcache2mem_addr  input  64, and dcache2mem_data  input  64: load/store requester.
REQ-007 SHALL have ports proc2mem_command  output  2, proc2mem_addr  output  64, and proc2mem_data  output  64: to memory.
REQ-008 SHALL have ports mem2proc_response  input  4, mem2proc_tag  input  4, and mem2proc_data  input  64: from memory; response 0 = rejected.
REQ-009 SHALL have ports mem2icache_response  output  4, mem2icache_tag  output  4, and mem2icache_data  output  64.
REQ-010 SHALL have ports mem2dcache_response  output  4, mem2dcache_tag  output  4, and mem2dcache_data  output  64.
REQ-011 SHALL have port tag_error  output  1  sticky flag: data returned on a tag with no pending load.

Function
REQ-012 A requester SHALL be active when its command is BUS_LOAD or BUS_STORE; command 2'd3 SHALL be treated as BUS_NONE.
REQ-013 Arbitration SHALL be combinational from registered state: one active requester wins outright; if both are active, winner = requester selected by priority register prio (0 = dcache, 1 = icache).
REQ-014 The winner's command/addr/data SHALL drive proc2mem_* in the same cycle; icache winner drives proc2mem_data = 0; no winner drives BUS_NONE, addr 0, data 0.
REQ-015 mem2proc_response SHALL be routed combinationally to the current winner's *_response output; the loser's response SHALL be 0.
REQ-016 Acceptance = winner exists AND mem2proc_response != 0; on posedge with acceptance, prio SHALL point to the non-winner (round robin).
REQ-017 Without acceptance (response 0), prio SHALL hold, so an unchanged request pair re-arbitrates to the same winner next cycle.
REQ-018 SHALL keep per-tag registers owner[1..NUM_MEM_TAGS] (0 = dcache, 1 = icache) and pending[1..NUM_MEM_TAGS].
REQ-019 On an accepted BUS_LOAD, owner[response] SHALL be set to the winner and pending[response] set to 1 at posedge.
REQ-020 An accepted BUS_STORE SHALL NOT modify owner or pending.
REQ-021 When mem2proc_tag != 0 and pending[tag] = 1, tag and data SHALL be routed combinationally to owner[tag]'s *_tag/*_data outputs; the other requester's outputs SHALL be 0.
REQ-022 In that case, pending[tag] SHALL be cleared at posedge.
REQ-023 When mem2proc_tag != 0 and pending[tag] = 0, both *_tag outputs SHALL be 0 and tag_error SHALL be set at posedge.
REQ-024 If the returning tag equals the newly accepted load tag in the same cycle, the return SHALL use the old owner; at posedge the new allocation SHALL win (pending = 1, owner = new winner).
REQ-025 Tag values above NUM_MEM_TAGS SHALL be ignored for routing and bookkeeping and SHALL set tag_error.
REQ-026 Latency: request-to-memory 0 cycles; response routing 0 cycles; data routing 0 cycles; bookkeeping visible next cycle.

Reset
REQ-027 While reset = 0, regardless of clock: prio = 0, all owner = 0, all pending = 0, tag_error = 0.
REQ-028 While reset = 0, proc2mem_command SHALL be BUS_NONE, and all *_response and *_tag outputs SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL discard all pending tags; later returns on those tags SHALL set tag_error.

Verification
REQ-030 Both load, addr 0x100 (dcache) / 0x200 (icache), response 3, from reset -> proc2mem_addr 0x100, mem2dcache_response 3; next cycle proc2mem_addr 0x200.
REQ-031 Both requesting, response 0 for 3 cycles -> dcache stays winner every cycle, prio stays 0; then response 5 -> mem2dcache_response 5, prio = 1.
REQ-032 icache load accepted on tag 2, later mem2proc_tag 2 with data 0xDEADBEEF -> mem2icache_tag 2, data 0xDEADBEEF, mem2dcache_tag 0, pending[2] cleared.
REQ-033 dcache store accepted on tag 4, later mem2proc_tag 4 -> both *_tag outputs 0, tag_error = 1.
REQ-034 Same cycle: tag 1 returns (owner icache) while dcache load accepted on tag 1 -> icache receives data; next cycle owner[1] = dcache, pending[1] = 1.
REQ-035 Pulse reset low between negedge and posedge with 2 loads pending -> immediate clear; later return on either tag -> tag_error = 1, no routing.
